// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register window addresses,
// CTRL register bit positions and miss-counter width.
package irq_ctrl_pkg;

   localparam logic [1:0] REG_PEND  = 2'd0;
   localparam logic [1:0] REG_MASK  = 2'd1;
   localparam logic [1:0] REG_CAUSE = 2'd2;
   localparam logic [1:0] REG_CTRL  = 2'd3;

   localparam int unsigned GEN_BIT      = 0;
   localparam int unsigned MISS_CLR_BIT = 1;
   localparam int unsigned MISS_LSB     = 8;
   localparam int unsigned MISS_W       = 8;

   localparam int unsigned CAUSE_VALID_BIT = 31;

   typedef logic [MISS_W-1:0] miss_t;

   // Saturating increment used by the miss counter.
   function automatic miss_t miss_sat_inc(input miss_t val);
      return (val == '1) ? val : val + miss_t'(1);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: index of the lowest-numbered set bit of
// vec_i (bit 0 wins) plus a valid flag; index is 0 when nothing is set.
module irq_prio_enc #(
   parameter int unsigned N_SRC = 8
) (
   input  logic [N_SRC-1:0] vec_i,
   output logic [3:0]       idx_o,
   output logic             valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = |vec_i;
      // Walk downward so the lowest set index is the last one assigned.
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-detects N_SRC sources into pending
// bits, applies mask/global enable and drives a registered int_out.
// Define IRQ_CTRL_SYNC_EN to insert a SYNC_STAGES flop synchronizer per source.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             int_we,
   input  logic [1:0]       int_addr,
   input  logic [31:0]      int_wdata,
   output logic [31:0]      int_rdata,
   output logic             int_out
);

   if (N_SRC < 1 || N_SRC > 16) begin : g_bad_n_src
      $error("irq_ctrl: N_SRC must be in 1..16");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
      $error("irq_ctrl: SYNC_STAGES must be in 2..3");
   end

   logic [N_SRC-1:0] src_lvl;
   logic [N_SRC-1:0] prev_q;
   logic [N_SRC-1:0] src_rise;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] clr;
   logic             gen_q, gen_d;
   miss_t            miss_q, miss_d;
   logic             int_out_q, int_out_d;
   logic             wr_pend, wr_mask, wr_ctrl;
   logic             miss_hit;
   logic [3:0]       cause_idx;
   logic             cause_valid;

`ifdef IRQ_CTRL_SYNC_EN
   logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign src_lvl = sync_q[SYNC_STAGES-1];
`else
   assign src_lvl = irq_src;
`endif

   assign src_rise = src_lvl & ~prev_q;

   assign wr_pend = int_we && (int_addr == REG_PEND);
   assign wr_mask = int_we && (int_addr == REG_MASK);
   assign wr_ctrl = int_we && (int_addr == REG_CTRL);

   assign clr = wr_pend ? int_wdata[N_SRC-1:0] : '0;

   // A bit being cleared this cycle does not count as a miss; set wins over W1C.
   assign miss_hit = |(src_rise & pend_q & ~clr);

   always_comb begin
      pend_d    = (pend_q & ~clr) | src_rise;
      mask_d    = mask_q;
      gen_d     = gen_q;
      miss_d    = miss_q;
      int_out_d = gen_q & |(pend_q & mask_q);

      if (wr_mask) begin
         mask_d = int_wdata[N_SRC-1:0];
      end
      if (wr_ctrl) begin
         gen_d = int_wdata[GEN_BIT];
      end
      if (wr_ctrl && int_wdata[MISS_CLR_BIT]) begin
         miss_d = '0;
      end else if (miss_hit) begin
         miss_d = miss_sat_inc(miss_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         gen_q     <= 1'b0;
         miss_q    <= '0;
         int_out_q <= 1'b0;
      end else begin
         prev_q    <= src_lvl;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         gen_q     <= gen_d;
         miss_q    <= miss_d;
         int_out_q <= int_out_d;
      end
   end

   irq_prio_enc #(
      .N_SRC (N_SRC)
   ) u_prio_enc (
      .vec_i   (pend_q & mask_q),
      .idx_o   (cause_idx),
      .valid_o (cause_valid)
   );

   always_comb begin
      int_rdata = '0;
      unique case (int_addr)
         REG_PEND:  int_rdata[N_SRC-1:0] = pend_q;
         REG_MASK:  int_rdata[N_SRC-1:0] = mask_q;
         REG_CAUSE: begin
            int_rdata[CAUSE_VALID_BIT] = cause_valid;
            int_rdata[3:0]             = cause_idx;
         end
         REG_CTRL: begin
            int_rdata[GEN_BIT]                = gen_q;
            int_rdata[MISS_LSB +: MISS_W]     = miss_q;
         end
         default:   int_rdata = '0;
      endcase
   end

   assign int_out = int_out_q;

   logic unused_wdata;
   assign unused_wdata = ^int_wdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected values are queued as stimulus
// is applied and popped when the DUT output is sampled.
module tb_irq_ctrl;

   localparam int unsigned N_SRC       = 8;
   localparam int unsigned SYNC_STAGES = 2;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int LAT = int'(SYNC_STAGES) + 1;
`else
   localparam int LAT = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_SRC-1:0] irq_src = '0;
   logic             int_we = 1'b0;
   logic [1:0]       int_addr = '0;
   logic [31:0]      int_wdata = '0;
   logic [31:0]      int_rdata;
   logic             int_out;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   irq_ctrl #(
      .N_SRC       (N_SRC),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src   (irq_src),
      .int_we    (int_we),
      .int_addr  (int_addr),
      .int_wdata (int_wdata),
      .int_rdata (int_rdata),
      .int_out   (int_out)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      int_we    = 1'b1;
      int_addr  = addr;
      int_wdata = data;
      tick();
      int_we    = 1'b0;
      int_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      int_addr = addr;
      #1;
      check(tag, int_rdata, exp_q.pop_front());
   endtask

   task automatic out(input logic exp, input string tag);
      exp_q.push_back({31'b0, exp});
      #1;
      check(tag, {31'b0, int_out}, exp_q.pop_front());
   endtask

   initial begin
      // Reset and idle register values
      ticks(3);
      rst = 1'b0;
      rd(2'd0, 32'h0, "rst_pend");
      rd(2'd1, 32'h0, "rst_mask");
      rd(2'd2, 32'h0, "rst_cause");
      rd(2'd3, 32'h0, "rst_ctrl");
      out(1'b0, "rst_int_out");

      // Single source, masked in, latency and W1C
      wr(2'd1, 32'h05);
      wr(2'd3, 32'h01);
      irq_src[2] = 1'b1;
      ticks(LAT);
      out(1'b0, "src2_int_out_early");
      rd(2'd0, 32'h04, "src2_pend");
      rd(2'd2, 32'h8000_0002, "src2_cause");
      tick();
      out(1'b1, "src2_int_out");
      irq_src[2] = 1'b0;
      wr(2'd0, 32'h04);
      rd(2'd0, 32'h0, "src2_pend_clr");
      tick();
      out(1'b0, "src2_int_out_clr");

      // Mask width, read-only CAUSE, priority
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1, 32'h0000_00FF, "mask_width");
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2, 32'h0, "cause_ro");
      irq_src = 8'h05;
      ticks(LAT);
      rd(2'd0, 32'h05, "prio_pend");
      rd(2'd2, 32'h8000_0000, "prio_cause0");
      irq_src = '0;
      wr(2'd0, 32'h01);
      rd(2'd2, 32'h8000_0002, "prio_cause2");
      wr(2'd0, 32'h04);
      rd(2'd0, 32'h0, "prio_pend_clr");

      // Set wins over W1C; no miss when the bit is being cleared
      irq_src[3] = 1'b1;
      ticks(LAT);
      rd(2'd0, 32'h08, "sw_pend_first");
      irq_src[3] = 1'b0;
      ticks(LAT + 1);
      irq_src[3] = 1'b1;
      ticks(LAT - 1);
      wr(2'd0, 32'h08);
      rd(2'd0, 32'h08, "sw_pend_kept");
      rd(2'd3, 32'h01, "sw_no_miss");
      irq_src[3] = 1'b0;
      ticks(LAT + 1);
      irq_src[3] = 1'b1;
      ticks(LAT + 1);
      rd(2'd3, 32'h0101, "miss_one");
      wr(2'd3, 32'h03);
      rd(2'd3, 32'h01, "miss_clr_gen1");
      irq_src[3] = 1'b0;
      ticks(LAT + 1);

      // Miss counter saturation
      wr(2'd3, 32'h00);
      for (int i = 0; i < 300; i++) begin
         irq_src[1] = 1'b1;
         tick();
         irq_src[1] = 1'b0;
         tick();
      end
      ticks(LAT + 1);
      rd(2'd3, 32'h0000_FF00, "miss_sat");
      rd(2'd0, 32'h0A, "miss_pend");
      wr(2'd3, 32'h02);
      rd(2'd3, 32'h0, "miss_clr_gen0");

      // Asynchronous reset while interrupting; source held across release
      wr(2'd3, 32'h01);
      tick();
      out(1'b1, "pre_rst_int_out");
      irq_src[4] = 1'b1;
      #2 rst = 1'b1;
      out(1'b0, "async_rst_int_out");
      rd(2'd0, 32'h0, "async_rst_pend");
      rd(2'd1, 32'h0, "async_rst_mask");
      rd(2'd2, 32'h0, "async_rst_cause");
      rd(2'd3, 32'h0, "async_rst_ctrl");
      @(negedge clk);
      rst = 1'b0;
      rd(2'd0, 32'h0, "rel_pend_before");
      ticks(LAT);
      rd(2'd0, 32'h10, "rel_pend_held");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
